// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues instruction-memory reads at pc, buffers tagged responses in an
// in-order queue and hands them to decode; a flush empties the queue and drops responses still in flight.
module instr_fetch_unit #(
    parameter int unsigned INSTR_ADDR_WIDTH = 20,
    parameter int unsigned INSTR_WIDTH      = 32,
    parameter int unsigned DEPTH            = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [INSTR_ADDR_WIDTH-1:0] pc,
    output logic                        pc_en,
    input  logic                        flush,
    input  logic                        halt,
    output logic                        imem_req_valid,
    input  logic                        imem_req_ready,
    output logic [INSTR_ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                        imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0]      imem_rsp_data,
    output logic                        instr_valid,
    output logic [INSTR_WIDTH-1:0]      instr,
    output logic [INSTR_ADDR_WIDTH-1:0] instr_pc,
    input  logic                        instr_ready
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = CW + 1;

    logic [INSTR_ADDR_WIDTH-1:0] pc_q   [DEPTH];
    logic [INSTR_WIDTH-1:0]      data_q [DEPTH];
    logic [DEPTH-1:0]            filled_q;

    logic [PW-1:0] alloc_ptr;
    logic [PW-1:0] fill_ptr;
    logic [PW-1:0] head_ptr;
    logic [CW-1:0] cnt;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] pend_cnt;
    logic          rst_state;

    logic          accept;
    logic          rsp_live;
    logic          rsp_drop;
    logic          deq;
    logic [SW-1:0] used;
    logic [SW-1:0] drop_flush;

    // Credit covers both live and discarded fetches so total in flight never exceeds DEPTH.
    assign used           = SW'(cnt) + SW'(drop_cnt);
    assign imem_req_valid = !rst_state && !flush && !halt && (used < SW'(DEPTH));
    assign imem_req_addr  = pc;
    assign accept         = imem_req_valid && imem_req_ready;
    assign pc_en          = accept || (flush && !rst);

    assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);
    assign rsp_live = imem_rsp_valid && (drop_cnt == '0) && (cnt != '0);

    assign instr_valid = (cnt != '0) && filled_q[head_ptr];
    assign instr       = data_q[head_ptr];
    assign instr_pc    = pc_q[head_ptr];
    assign deq         = instr_valid && instr_ready && !flush;

    // Everything still outstanding after this cycle's response becomes a discard.
    assign drop_flush = SW'(drop_cnt) + SW'(pend_cnt) - SW'(rsp_live) - SW'(rsp_drop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_state <= 1'b1;
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            cnt       <= '0;
            drop_cnt  <= '0;
            pend_cnt  <= '0;
        end else begin
            rst_state <= 1'b0;
            if (flush) begin
                alloc_ptr <= '0;
                fill_ptr  <= '0;
                head_ptr  <= '0;
                cnt       <= '0;
                pend_cnt  <= '0;
                drop_cnt  <= CW'(drop_flush);
            end else begin
                if (accept) begin
                    alloc_ptr <= alloc_ptr + PW'(1);
                end
                if (rsp_live) begin
                    fill_ptr <= fill_ptr + PW'(1);
                end
                if (deq) begin
                    head_ptr <= head_ptr + PW'(1);
                end
                if (rsp_drop) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
                cnt      <= cnt + CW'(accept) - CW'(deq);
                pend_cnt <= pend_cnt + CW'(accept) - CW'(rsp_live && (pend_cnt != '0));
            end
        end
    end

    // Entry storage: tail allocation records the pc, fill pointer captures returned data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_q[PW'(i)]   <= '0;
                data_q[PW'(i)] <= '0;
            end
            filled_q <= '0;
        end else if (!flush) begin
            if (accept) begin
                pc_q[alloc_ptr]     <= pc;
                filled_q[alloc_ptr] <= 1'b0;
            end
            if (rsp_live) begin
                data_q[fill_ptr]   <= imem_rsp_data;
                filled_q[fill_ptr] <= 1'b1;
            end
        end
    end

    no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
        !(imem_rsp_valid && (cnt == '0) && (drop_cnt == '0)))
        else $error("instr_fetch_unit: response with nothing outstanding");

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: a pc counter, an in-order memory and a
// stream-level model of which fetched instructions must reach decode.
module tb_instr_fetch_unit;

    localparam int AW    = 20;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    typedef struct {
        logic [AW-1:0] addr;
        int            due;
        int            epoch;
    } mreq_t;

    logic          clk;
    logic          rst;
    logic [AW-1:0] pc;
    logic          pc_en;
    logic          flush;
    logic          halt;
    logic          imem_req_valid;
    logic          imem_req_ready;
    logic [AW-1:0] imem_req_addr;
    logic          imem_rsp_valid;
    logic [DW-1:0] imem_rsp_data;
    logic          instr_valid;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_ready;

    instr_fetch_unit #(
        .INSTR_ADDR_WIDTH(AW),
        .INSTR_WIDTH     (DW),
        .DEPTH           (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pc            (pc),
        .pc_en         (pc_en),
        .flush         (flush),
        .halt          (halt),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_ready   (instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;
    int cyc;
    int epoch;
    int n_arr;
    int last_due;
    int lat_min, lat_max, p_ready, p_iready, p_flush, budget;
    logic halt_knob, force_flush;
    logic obs_acc, obs_deq, obs_rsp, obs_pen;
    logic [AW-1:0] obs_pc, obs_addr, last_target;
    mreq_t         mem_q[$];
    logic [AW-1:0] live_q[$];

    function automatic logic [DW-1:0] mem_data(logic [AW-1:0] a);
        return (DW'(a) * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    task automatic model_clear();
        mem_q.delete();
        live_q.delete();
        n_arr       = 0;
        pc          = '0;
        last_due    = cyc;
        budget      = -1;
        halt_knob   = 1'b0;
        force_flush = 1'b0;
    endtask

    task automatic idle_inputs();
        flush          = 1'b0;
        halt           = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        instr_ready    = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock of stimulus; the model predicts outputs from the fetch/delivery stream.
    task automatic cycle();
        logic  exp_req, exp_pen, exp_iv, acc, deq, rsp;
        int    lat, due;
        mreq_t m;
        @(negedge clk);
        rsp            = (mem_q.size() > 0) && (mem_q[0].due <= cyc + 1);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_data(mem_q[0].addr) : DW'($urandom);
        imem_req_ready = (budget != 0) && (int'($urandom_range(99)) < p_ready);
        instr_ready    = int'($urandom_range(99)) < p_iready;
        flush          = force_flush || (int'($urandom_range(999)) < p_flush);
        force_flush    = 1'b0;
        halt           = halt_knob;
        #1;
        exp_req = !flush && !halt && (mem_q.size() + n_arr < DEPTH);
        exp_pen = (exp_req && imem_req_ready) || flush;
        exp_iv  = n_arr > 0;
        vectors++;
        if (instr_valid !== exp_iv) begin
            miscompares++;
            $display("FAIL instr_valid cyc=%0d got=%b exp=%b", cyc, instr_valid, exp_iv);
        end
        if (exp_iv) begin
            vectors++;
            if (instr_pc !== live_q[0]) begin
                miscompares++;
                $display("FAIL instr_pc cyc=%0d got=%h exp=%h", cyc, instr_pc, live_q[0]);
            end
            vectors++;
            if (instr !== mem_data(live_q[0])) begin
                miscompares++;
                $display("FAIL instr cyc=%0d got=%h exp=%h", cyc, instr, mem_data(live_q[0]));
            end
        end
        vectors++;
        if (imem_req_valid !== exp_req) begin
            miscompares++;
            $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid, exp_req);
        end
        if (exp_req) begin
            vectors++;
            if (imem_req_addr !== pc) begin
                miscompares++;
                $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, pc);
            end
        end
        vectors++;
        if (pc_en !== exp_pen) begin
            miscompares++;
            $display("FAIL pc_en cyc=%0d got=%b exp=%b", cyc, pc_en, exp_pen);
        end
        obs_acc  = imem_req_valid && imem_req_ready;
        obs_deq  = instr_valid && instr_ready;
        obs_rsp  = rsp;
        obs_pen  = pc_en;
        obs_pc   = instr_pc;
        obs_addr = imem_req_addr;
        acc = exp_req && imem_req_ready;
        deq = exp_iv && instr_ready && !flush;
        @(posedge clk);
        cyc++;
        if (rsp) begin
            m = mem_q.pop_front();
            if (!flush && m.epoch == epoch) n_arr++;
        end
        if (flush) begin
            live_q.delete();
            n_arr = 0;
            epoch++;
        end else begin
            if (deq) begin
                void'(live_q.pop_front());
                n_arr--;
            end
            if (acc) begin
                lat = int'($urandom_range(lat_max, lat_min));
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                mem_q.push_back('{addr: pc, due: due, epoch: epoch});
                live_q.push_back(pc);
                if (budget > 0) budget--;
            end
        end
        #1;
        if (flush) begin
            last_target = AW'($urandom);
            pc          = last_target;
        end else if (exp_pen) begin
            pc = pc + AW'(1);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        model_clear();
        flush = 1'b1;
        #2;
        vectors += 5;
        if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL rst_instr_valid got=%b exp=0", instr_valid); end
        if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL rst_req_valid got=%b exp=0", imem_req_valid); end
        if (pc_en !== 1'b0) begin miscompares++; $display("FAIL rst_pc_en got=%b exp=0", pc_en); end
        if (instr !== '0) begin miscompares++; $display("FAIL rst_instr got=%h exp=0", instr); end
        if (instr_pc !== '0) begin miscompares++; $display("FAIL rst_instr_pc got=%h exp=0", instr_pc); end
        flush = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (imem_req_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_state_req got=%b exp=0", imem_req_valid);
        end
    endtask

    task automatic test_stream();
        int deqs;
        lat_min = 1; lat_max = 1; p_ready = 100; p_iready = 100; p_flush = 0;
        deqs = 0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (obs_deq) deqs++;
        end
        vectors++;
        if (deqs !== 28) begin
            miscompares++;
            $display("FAIL stream_throughput got=%0d exp=28", deqs);
        end
    endtask

    task automatic test_full();
        int accs;
        do_reset();
        lat_min = 1; lat_max = 1; p_ready = 100; p_iready = 0; p_flush = 0;
        accs = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (obs_acc) accs++;
        end
        vectors += 2;
        if (accs !== DEPTH) begin miscompares++; $display("FAIL full_accepts got=%0d exp=%0d", accs, DEPTH); end
        if (obs_pen !== 1'b0) begin miscompares++; $display("FAIL full_pc_en got=%b exp=0", obs_pen); end
        p_iready = 100;
        cycle();
        p_iready = 0;
        vectors += 2;
        if (obs_deq !== 1'b1) begin miscompares++; $display("FAIL full_release_deq got=%b exp=1", obs_deq); end
        if (obs_pc !== '0) begin miscompares++; $display("FAIL full_head_pc got=%h exp=0", obs_pc); end
        cycle();
        vectors++;
        if (obs_acc !== 1'b1) begin miscompares++; $display("FAIL full_refill got=%b exp=1", obs_acc); end
    endtask

    task automatic test_flush();
        int  n;
        logic seen;
        do_reset();
        lat_min = 3; lat_max = 3; p_ready = 100; p_iready = 0; p_flush = 0;
        budget = 3;
        n = 0;
        while (!(n_arr == 1 && mem_q.size() == 2) && n < 40) begin
            cycle();
            n++;
        end
        vectors++;
        if (n >= 40) begin miscompares++; $display("FAIL flush_setup timeout after %0d cycles", n); end
        force_flush = 1'b1;
        budget      = -1;
        cycle();
        vectors += 2;
        if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL flush_valid got=%b exp=0", instr_valid); end
        if (int'(dut.drop_cnt) !== mem_q.size()) begin
            miscompares++;
            $display("FAIL flush_drop_cnt got=%0d exp=%0d", dut.drop_cnt, mem_q.size());
        end
        p_iready = 100;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            cycle();
            seen = obs_deq;
        end
        vectors++;
        if (!seen || obs_pc !== last_target) begin
            miscompares++;
            $display("FAIL flush_target seen=%b got=%h exp=%h", seen, obs_pc, last_target);
        end
    endtask

    task automatic test_flush_rsp_deq();
        do_reset();
        lat_min = 1; lat_max = 1; p_ready = 100; p_iready = 100; p_flush = 0;
        repeat (8) cycle();
        force_flush = 1'b1;
        cycle();
        vectors += 3;
        if (!(obs_rsp && obs_deq)) begin
            miscompares++;
            $display("FAIL frd_overlap rsp=%b deq=%b exp=1/1", obs_rsp, obs_deq);
        end
        if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL frd_valid got=%b exp=0", instr_valid); end
        if (int'(dut.drop_cnt) !== mem_q.size()) begin
            miscompares++;
            $display("FAIL frd_drop_cnt got=%0d exp=%0d", dut.drop_cnt, mem_q.size());
        end
        repeat (12) cycle();
    endtask

    task automatic test_halt();
        int n, deqs, pens;
        do_reset();
        lat_min = 3; lat_max = 3; p_ready = 100; p_iready = 100; p_flush = 0;
        budget = 2;
        n = 0;
        while (mem_q.size() != 2 && n < 20) begin
            cycle();
            n++;
        end
        halt_knob = 1'b1;
        budget    = -1;
        deqs = 0; pens = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (obs_deq) deqs++;
            if (obs_pen) pens++;
        end
        vectors += 2;
        if (deqs !== 2) begin miscompares++; $display("FAIL halt_drain got=%0d exp=2", deqs); end
        if (pens !== 0) begin miscompares++; $display("FAIL halt_pc_en got=%0d exp=0", pens); end
        halt_knob = 1'b0;
        cycle();
        vectors++;
        if (obs_pen !== 1'b1) begin miscompares++; $display("FAIL halt_resume got=%b exp=1", obs_pen); end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        lat_min = 1; lat_max = 1; p_ready = 100; p_iready = 0; p_flush = 0;
        n = 0;
        while (n_arr != 3 && n < 20) begin
            cycle();
            n++;
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        vectors += 4;
        if (n >= 20) begin miscompares++; $display("FAIL rmid_setup timeout after %0d cycles", n); end
        if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_valid got=%b exp=0", instr_valid); end
        if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_req got=%b exp=0", imem_req_valid); end
        if (pc_en !== 1'b0) begin miscompares++; $display("FAIL rmid_pc_en got=%b exp=0", pc_en); end
        idle_inputs();
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        p_iready = 100;
        cycle();
        vectors++;
        if (!(obs_acc && obs_addr === '0)) begin
            miscompares++;
            $display("FAIL rmid_restart acc=%b got=%h exp=0", obs_acc, obs_addr);
        end
        repeat (15) cycle();
    endtask

    task automatic test_random();
        do_reset();
        lat_min = 1; lat_max = 4; p_ready = 70; p_iready = 60; p_flush = 40;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(15) == 0) halt_knob = ~halt_knob;
            cycle();
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0; cyc = 0; epoch = 0;
        last_target = '0;
        rst = 1'b1;
        idle_inputs();
        model_clear();
        lat_min = 1; lat_max = 1; p_ready = 0; p_iready = 0; p_flush = 0;
        test_reset();
        test_stream();
        test_full();
        test_flush();
        test_flush_rsp_deq();
        test_halt();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
